// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell reused across WIDTH clock
// cycles, LSB first, with the carry held in a register between bits.

module full_adder (
  input  logic x1,
  input  logic x2,
  input  logic cin,
  output logic y,
  output logic cout
);
  assign y    = x1 ^ x2 ^ cin;
  assign cout = (x1 & x2) | (x1 & cin) | (x2 & cin);
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit pair added per clock, LSB first
// DONE  | result published, done high; start here reloads without a bubble
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa_sh;
  logic [WIDTH-1:0] opb_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;

  logic             fa_y;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  full_adder fa (
    .x1   (opa_sh[0]),
    .x2   (opb_sh[0]),
    .cin  (carry_r),
    .y    (fa_y),
    .cout (fa_cout)
  );

  // res_sh keeps only the upper WIDTH-1 bits of the partial result; the
  // bit from the current cycle completes it when the last bit is added.
  assign res_next = {fa_y, res_sh};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opa_sh  <= '0;
      opb_sh  <= '0;
      res_sh  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa_sh  <= a;
            opb_sh  <= b;
            carry_r <= cin;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          res_sh  <= res_next[WIDTH-1:1];
          carry_r <= fa_cout;
          opa_sh  <= {1'b0, opa_sh[WIDTH-1:1]};
          opb_sh  <= {1'b0, opb_sh[WIDTH-1:1]};
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum   <= res_next;
            cout  <= fa_cout;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [7:0]  sum;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // Issue one request on the 8-bit DUT; n = edges from the start-sample edge
  // (counted as 1) to the first sample with done high, or -1 on timeout.
  // Operands are scrambled right after the sample edge.
  task automatic run8(input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, output int n);
    start = 1'b1; a = va; b = vb; cin = vc;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      if (done) begin n = i; break; end
    end
  endtask

  task automatic run16(input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, output int n);
    start16 = 1'b1; a16 = va; b16 = vb; cin16 = vc;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      end
      if (done16) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 4;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
    if (sum !== 8'h00) begin n_errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
    if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n;
    run8(8'h03, 8'h05, 1'b0, n);
    n_checks += 3;
    if (n !== 9) begin n_errors++; $display("FAIL basic_latency got=%0d exp=9", n); end
    if (sum !== 8'h08) begin n_errors++; $display("FAIL basic_sum got=%h exp=08", sum); end
    if (cout !== 1'b0) begin n_errors++; $display("FAIL basic_cout got=%b exp=0", cout); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
  endtask

  task automatic test_carry();
    int n;
    logic [7:0] exp_sum;
    run8(8'hFF, 8'h01, 1'b0, n);
    n_checks += 3;
    if (n !== 9) begin n_errors++; $display("FAIL carry1_latency got=%0d exp=9", n); end
    if (sum !== 8'h00) begin n_errors++; $display("FAIL carry1_sum got=%h exp=00", sum); end
    if (cout !== 1'b1) begin n_errors++; $display("FAIL carry1_cout got=%b exp=1", cout); end
    run8(8'hFF, 8'hFF, 1'b1, n);
    n_checks += 3;
    if (n !== 9) begin n_errors++; $display("FAIL carry2_latency got=%0d exp=9", n); end
    if (sum !== 8'hFF) begin n_errors++; $display("FAIL carry2_sum got=%h exp=FF", sum); end
    if (cout !== 1'b1) begin n_errors++; $display("FAIL carry2_cout got=%b exp=1", cout); end
    for (int k = 0; k < 8; k++) begin
      logic ba, bb, bc;
      ba = k[2]; bb = k[1]; bc = k[0];
      exp_sum = {6'b0, (ba & bb) | (ba & bc) | (bb & bc), ba ^ bb ^ bc};
      run8({7'b0, ba}, {7'b0, bb}, bc, n);
      n_checks += 2;
      if (n !== 9) begin n_errors++; $display("FAIL tt_latency k=%0d got=%0d exp=9", k, n); end
      if ({cout, sum} !== {1'b0, exp_sum}) begin
        n_errors++;
        $display("FAIL tt_sum k=%0d got=%b_%h exp=0_%h", k, cout, sum, exp_sum);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin start = 1'b0; a = 8'h00; b = 8'h00; end
      if (i == 3) begin start = 1'b1; a = 8'h7F; b = 8'h7F; end
      if (i == 7) start = 1'b0;
      if (done) begin
        pulses++;
        n_checks += 3;
        if (i !== 9) begin n_errors++; $display("FAIL ignore_latency got=%0d exp=9", i); end
        if (sum !== 8'h30) begin n_errors++; $display("FAIL ignore_sum got=%h exp=30", sum); end
        if (cout !== 1'b0) begin n_errors++; $display("FAIL ignore_cout got=%b exp=0", cout); end
      end
    end
    n_checks++;
    if (pulses !== 1) begin n_errors++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks += 4;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done got=%b exp=0", done); end
    if (sum !== 8'h00) begin n_errors++; $display("FAIL abort_sum got=%h exp=00", sum); end
    if (cout !== 1'b0) begin n_errors++; $display("FAIL abort_cout got=%b exp=0", cout); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1, bad_busy = 0;
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin a = 8'h80; b = 8'h80; end
      if (i == 10) start = 1'b0;
      if (i <= 18 && busy !== !done) bad_busy++;
      if (done && first < 0) begin
        first = i;
        n_checks += 2;
        if (sum !== 8'h02) begin n_errors++; $display("FAIL b2b_sum1 got=%h exp=02", sum); end
        if (cout !== 1'b0) begin n_errors++; $display("FAIL b2b_cout1 got=%b exp=0", cout); end
      end else if (done && second < 0) begin
        second = i;
        n_checks += 2;
        if (sum !== 8'h00) begin n_errors++; $display("FAIL b2b_sum2 got=%h exp=00", sum); end
        if (cout !== 1'b1) begin n_errors++; $display("FAIL b2b_cout2 got=%b exp=1", cout); end
      end
      if (i == 5) begin
        n_checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
          n_errors++; $display("FAIL b2b_hold got=%b_%h exp=0_00", cout, sum);
        end
      end
    end
    n_checks += 3;
    if (first !== 9) begin n_errors++; $display("FAIL b2b_first got=%0d exp=9", first); end
    if (second !== 18) begin n_errors++; $display("FAIL b2b_second got=%0d exp=18", second); end
    if (bad_busy !== 0) begin n_errors++; $display("FAIL b2b_busy got=%0d bad cycles exp=0", bad_busy); end
  endtask

  task automatic test_random();
    int n;
    logic [7:0]  ra, rb;
    logic [15:0] qa, qb;
    logic        rc;
    logic [8:0]  e8;
    logic [16:0] e16;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      e8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run8(ra, rb, rc, n);
      n_checks++;
      if (n !== 9 || {cout, sum} !== e8) begin
        n_errors++;
        $display("FAIL rand8 a=%h b=%h c=%b got=%b_%h lat=%0d exp=%h lat=9", ra, rb, rc, cout, sum, n, e8);
      end
    end
    for (int k = 0; k < 1000; k++) begin
      qa = 16'($urandom); qb = 16'($urandom); rc = 1'($urandom);
      e16 = {1'b0, qa} + {1'b0, qb} + {16'b0, rc};
      run16(qa, qb, rc, n);
      n_checks++;
      if (n !== 17 || {cout16, sum16} !== e16) begin
        n_errors++;
        $display("FAIL rand16 a=%h b=%h c=%b got=%b_%h lat=%0d exp=%h lat=17", qa, qb, rc, cout16, sum16, n, e16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that time-multiplexes a single `full_adder` instance across a WIDTH-bit operand pair.
- Latches operands on a start request and feeds the adder one bit per clock, LSB first, carrying the carry-out forward between cycles.
- Assembles the sum and reports completion with a one-cycle done pulse.
- Sits between a requesting datapath/sequencer and the existing `full_adder` cell, trading latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  initial carry-in; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; holds the last completed result.
- cout  output  1  final carry of the last completed result.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry reg and counter cleared. Reset dominates start at the same edge and aborts any RUN with no done pulse.
- Datapath: exactly one `full_adder` instance. x1=opA_sh[0], x2=opB_sh[0], cin=carry_r. No `+` operator is used for the sum path.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load opA_sh=a, opB_sh=b, carry_r=cin, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - res_sh <= {fa.y, res_sh[WIDTH-1:1]}.
  - carry_r <= fa.cout.
  - opA_sh and opB_sh shift right by 1 (zero fill).
  - cnt <= cnt+1.
  - start is ignored throughout RUN.
- RUN exit: on the edge where cnt==WIDTH-1, also:
  - sum <= {fa.y, res_sh[WIDTH-1:1]}.
  - cout <= fa.cout.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 -> reload operands and go to RUN (back-to-back accept, no idle bubble).
  - Otherwise go to IDLE.
- Outputs are registered or decoded from state only: busy=(state==RUN), done=(state==DONE).
- sum and cout change only on the RUN->DONE edge or at reset. Between those events they hold their value, including throughout a following RUN.
- Latency: start sampled at edge k -> RUN during cycles k..k+WIDTH-1 -> done high in the cycle after edge k+WIDTH. Total of WIDTH+1 edges from start sample to done observed.
- Throughput: one result per WIDTH+1 cycles with start held high continuously.
- Arithmetic: {cout,sum} == a + b + cin, computed mod 2^(WIDTH+1).
- Wrap-around: the counter never exceeds WIDTH-1 in RUN and is reset on every load.
- Operand inputs may change freely after the start sample without affecting the result.
- Input X/undefined handling is out of scope.

Test Plan:
- WIDTH=8. After reset: busy=0, done=0, sum=0x00, cout=0. Pulse start with a=0x03, b=0x05, cin=0 -> done high exactly 9 edges after start sample; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Sweep all 8 combos of a[0]/b[0]/cin with upper bits 0 and check against the full-adder truth table.
- Start a=0x10, b=0x20. Mid-RUN, assert start with a=0x7F, b=0x7F -> second request ignored; result sum=0x30, cout=0; exactly one done pulse.
- Start a=0xAA, b=0x55. Assert rst for one edge at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse for 12 cycles after rst deasserts with start=0.
- Hold start=1 with a=0x01, b=0x01 then a=0x80, b=0x80 -> done pulses exactly every 9 cycles. Sums are 0x02/cout=0, then 0x00/cout=1. busy drops only during done cycles.
- Random: 1000 random (a,b,cin) for WIDTH=8 and WIDTH=16 -> {cout,sum} matches the reference model a+b+cin every time.
